// File: rtl/ram_ctrl_if.sv
// ram_ctrl_if: requester handshakes, read result and register-file port of ram_ctrl
interface ram_ctrl_if;
    logic       m0_req, m1_req;
    logic       m0_we, m1_we;
    logic [4:0] m0_addr, m1_addr;
    logic [7:0] m0_wdata, m1_wdata;
    logic       m0_gnt, m1_gnt;
    logic       m0_done, m1_done;
    logic [7:0] rdata;
    logic       busy;
    logic       ram_we;
    logic [4:0] ram_addr;
    logic [7:0] ram_wdata;
    logic [7:0] ram_rdata;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, ram_rdata,
        output m0_gnt, m1_gnt, m0_done, m1_done, rdata, busy, ram_we, ram_addr, ram_wdata
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  m0_gnt, m1_gnt, m0_done, m1_done, rdata, busy
    );

    modport mem (
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/ram_ctrl.sv
// ram_ctrl: round-robin two-requester controller for a 32x8 register file with INDF/FSR indirection
module ram_ctrl #(
    parameter logic [4:0] INDF_ADDR = 5'd0,
    parameter logic [4:0] FSR_ADDR  = 5'd4
) (
    input logic       clk,
    input logic       rst,
    ram_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, IND, INDW, ACC, RESP} state_t;

    state_t     r_state, w_next;
    logic       r_sel, r_last, r_we;
    logic [4:0] r_eff;
    logic [7:0] r_wdata, r_rdata;
    logic       w_gnt0, w_gnt1, w_null;
    logic [4:0] w_addr;
    logic [7:0] w_rdata;

    // r_last=1 means m1 was granted last, so a tie goes to m0; grants are masked while in reset
    assign w_gnt1  = rst && r_state == IDLE && bus.m1_req && (!bus.m0_req || !r_last);
    assign w_gnt0  = rst && r_state == IDLE && bus.m0_req && !w_gnt1;
    assign w_addr  = w_gnt1 ? bus.m1_addr : bus.m0_addr;
    assign w_null  = r_eff == INDF_ADDR;
    assign w_rdata = (r_we || w_null) ? 8'h00 : bus.ram_rdata;

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // next state and all outputs decoded from the current state
    always_comb begin
        w_next        = r_state;
        bus.m0_gnt    = w_gnt0;
        bus.m1_gnt    = w_gnt1;
        bus.m0_done   = r_state == RESP && !r_sel;
        bus.m1_done   = r_state == RESP && r_sel;
        bus.busy      = r_state != IDLE;
        bus.ram_we    = r_state == ACC && r_we && !w_null;
        bus.ram_addr  = r_state == IND ? FSR_ADDR : r_state == ACC ? r_eff : 5'd0;
        bus.ram_wdata = r_state == ACC ? r_wdata : 8'h00;
        bus.rdata     = r_state == RESP ? w_rdata : r_rdata;
        case (r_state)
            IDLE:    w_next = (w_gnt0 || w_gnt1) ? (w_addr == INDF_ADDR ? IND : ACC) : IDLE;
            IND:     w_next = INDW;
            INDW:    w_next = ACC;
            ACC:     w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // latch the granted request, resolve the FSR pointer, and keep the last read result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel   <= 1'b0;
            r_last  <= 1'b1;
            r_we    <= 1'b0;
            r_eff   <= 5'd0;
            r_wdata <= 8'h00;
            r_rdata <= 8'h00;
        end else begin
            if (w_gnt0 || w_gnt1) begin
                r_sel   <= w_gnt1;
                r_last  <= w_gnt1;
                r_we    <= w_gnt1 ? bus.m1_we : bus.m0_we;
                r_eff   <= w_addr;
                r_wdata <= w_gnt1 ? bus.m1_wdata : bus.m0_wdata;
            end
            if (r_state == INDW) r_eff <= bus.ram_rdata[4:0];
            if (r_state == RESP) r_rdata <= w_rdata;
        end
    end
endmodule

// File: tb/tb_ram_ctrl.sv
// tb_ram_ctrl: vector table, random traffic against a transaction-level model, contention and reset corner cases
module tb_ram_ctrl;
    localparam logic [4:0] INDF = 5'd0;
    localparam logic [4:0] FSR  = 5'd4;

    typedef struct {
        bit         p;
        bit         we;
        logic [4:0] a;
        logic [7:0] d;
        logic [7:0] rd;
        int         lat;
        int         wes;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    ram_ctrl_if bus();

    ram_ctrl #(.INDF_ADDR(INDF), .FSR_ADDR(FSR)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // register file: synchronous write, registered read address, not reset
    logic [7:0] mem [32] = '{default: 8'h00};
    logic [4:0] ra = 5'd0;
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
        ra <= bus.ram_addr;
    end
    assign bus.ram_rdata = mem[ra];

    logic [7:0] ref_mem [32] = '{default: 8'h00};
    int errs = 0;
    int checks = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // transaction-level reference: what one access should return and do to memory
    function automatic void model(input bit we, input logic [4:0] a, input logic [7:0] d,
                                  output logic [7:0] rd, output int lat, output int wes);
        logic [4:0] eff;
        bit nul;
        eff = (a == INDF) ? ref_mem[FSR][4:0] : a;
        nul = (eff == INDF);
        lat = (a == INDF) ? 4 : 2;
        wes = (we && !nul) ? 1 : 0;
        rd  = (we || nul) ? 8'h00 : ref_mem[eff];
        if (wes == 1) ref_mem[eff] = d;
    endfunction

    task automatic drive(input bit p, input bit r, input bit we, input logic [4:0] a, input logic [7:0] d);
        if (p) begin
            bus.m1_req = r; bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d;
        end else begin
            bus.m0_req = r; bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d;
        end
    endtask

    // one access: request until granted, then scramble the fields and count cycles to done
    task automatic access(input bit p, input bit we, input logic [4:0] a, input logic [7:0] d,
                          output logic [7:0] rd, output int lat, output int wes);
        bit g;
        g = 1'b0;
        @(posedge clk); #1;
        drive(p, 1'b1, we, a, d);
        for (int n = 0; n < 10 && !g; n++) begin
            @(negedge clk);
            g = p ? bus.m1_gnt : bus.m0_gnt;
        end
        chk("gnt_seen", 32'(g), 32'd1);
        @(posedge clk); #1;
        drive(p, 1'b0, 1'($urandom), 5'($urandom), 8'($urandom));
        lat = 0;
        wes = 0;
        rd  = 8'hxx;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            lat++;
            wes += int'(bus.ram_we);
            if (p ? bus.m1_done : bus.m0_done) begin
                rd = bus.rdata;
                break;
            end
        end
    endtask

    vec_t       tbl [12];
    logic [7:0] rd, mrd, old;
    int         lat, wes, mlat, mwes;
    int         last, ng, bad_both, bad_order, bad_gap, bad_busy, nlow, ndone;
    bit         rp, rwe;
    logic [4:0] ra_r;
    logic [7:0] rd_r;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{0, 1, 5'd8,  8'hA5, 8'h00, 2, 1};
        tbl[1]  = '{0, 0, 5'd8,  8'h00, 8'hA5, 2, 0};
        tbl[2]  = '{0, 1, 5'd4,  8'hE9, 8'h00, 2, 1};
        tbl[3]  = '{1, 1, 5'd9,  8'h3C, 8'h00, 2, 1};
        tbl[4]  = '{0, 0, 5'd0,  8'h00, 8'h3C, 4, 0};
        tbl[5]  = '{0, 1, 5'd4,  8'h00, 8'h00, 2, 1};
        tbl[6]  = '{0, 1, 5'd0,  8'hFF, 8'h00, 4, 0};
        tbl[7]  = '{1, 0, 5'd0,  8'h00, 8'h00, 4, 0};
        tbl[8]  = '{1, 0, 5'd4,  8'h00, 8'h00, 2, 0};
        tbl[9]  = '{1, 1, 5'd31, 8'h5A, 8'h00, 2, 1};
        tbl[10] = '{0, 1, 5'd4,  8'h3F, 8'h00, 2, 1};
        tbl[11] = '{0, 0, 5'd0,  8'h00, 8'h5A, 4, 0};

        drive(0, 1'b0, 1'b0, 5'd0, 8'h00);
        drive(1, 1'b0, 1'b0, 5'd0, 8'h00);
        #12;
        chk("rst_gnt",   32'({bus.m0_gnt, bus.m1_gnt}), 32'd0);
        chk("rst_done",  32'({bus.m0_done, bus.m1_done}), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_ramwe", 32'(bus.ram_we), 32'd0);
        chk("rst_ram",   32'({bus.ram_addr, bus.ram_wdata}), 32'd0);
        chk("rst_rdata", 32'(bus.rdata), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        foreach (tbl[i]) begin
            model(tbl[i].we, tbl[i].a, tbl[i].d, mrd, mlat, mwes);
            access(tbl[i].p, tbl[i].we, tbl[i].a, tbl[i].d, rd, lat, wes);
            chk($sformatf("vec%0d_rdata", i), 32'(rd), 32'(tbl[i].rd));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
            chk($sformatf("vec%0d_ram_we_cycles", i), 32'(wes), 32'(tbl[i].wes));
        end

        for (int i = 0; i < 40; i++) begin
            rp   = 1'($urandom);
            rwe  = 1'($urandom);
            rd_r = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       ra_r = INDF;
                1:       ra_r = FSR;
                default: ra_r = 5'($urandom);
            endcase
            model(rwe, ra_r, rd_r, mrd, mlat, mwes);
            access(rp, rwe, ra_r, rd_r, rd, lat, wes);
            chk($sformatf("rnd%0d_rdata", i), 32'(rd), 32'(mrd));
            chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(mlat));
            chk($sformatf("rnd%0d_ram_we_cycles", i), 32'(wes), 32'(mwes));
        end

        // contention: both requesters held high from reset onward
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b1, 1'b0, 5'd8, 8'h00);
        drive(1, 1'b1, 1'b0, 5'd9, 8'h00);
        #1;
        chk("cont_rst_gnt", 32'({bus.m0_gnt, bus.m1_gnt}), 32'd0);
        chk("cont_rst_busy", 32'(bus.busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        last = -2; ng = 0; bad_both = 0; bad_order = 0; bad_gap = 0; bad_busy = 0; nlow = 0;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            if (bus.m0_gnt && bus.m1_gnt) bad_both++;
            if (bus.busy == (bus.m0_gnt | bus.m1_gnt)) bad_busy++;
            if (!bus.busy) nlow++;
            if (bus.m0_gnt || bus.m1_gnt) begin
                if (bus.m1_gnt != bit'(ng & 1)) bad_order++;
                if (c - last != 3) bad_gap++;
                last = c;
                ng++;
            end
        end
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 5'd0, 8'h00);
        drive(1, 1'b0, 1'b0, 5'd0, 8'h00);
        chk("cont_grants", 32'(ng), 32'd8);
        chk("cont_double_gnt", 32'(bad_both), 32'd0);
        chk("cont_alternation", 32'(bad_order), 32'd0);
        chk("cont_gnt_spacing", 32'(bad_gap), 32'd0);
        chk("cont_busy_vs_gnt", 32'(bad_busy), 32'd0);
        chk("cont_busy_low_cycles", 32'(nlow), 32'd8);

        // reset during ACC of an m1 write must leave address 12 untouched
        model(1'b1, 5'd12, 8'h12, mrd, mlat, mwes);
        access(0, 1'b1, 5'd12, 8'h12, rd, lat, wes);
        chk("midop_prewrite_latency", 32'(lat), 32'(mlat));
        old = ref_mem[12];
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 5'd12, 8'h77);
        ng = 0;
        for (int n = 0; n < 10 && ng == 0; n++) begin
            @(negedge clk);
            ng = int'(bus.m1_gnt);
        end
        chk("midop_gnt", 32'(ng), 32'd1);
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 5'd0, 8'h00);
        chk("midop_ram_we_in_acc", 32'(bus.ram_we), 32'd1);
        rst = 1'b0;
        #1;
        chk("midop_async_ram_we", 32'(bus.ram_we), 32'd0);
        chk("midop_async_busy", 32'(bus.busy), 32'd0);
        ndone = 0;
        repeat (3) begin
            @(negedge clk);
            ndone += int'(bus.m0_done | bus.m1_done);
        end
        chk("midop_no_done", 32'(ndone), 32'd0);
        drive(0, 1'b1, 1'b0, 5'd12, 8'h00);
        drive(1, 1'b1, 1'b0, 5'd12, 8'h00);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midop_first_gnt", 32'({bus.m0_gnt, bus.m1_gnt}), 32'b10);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 5'd0, 8'h00);
        drive(1, 1'b0, 1'b0, 5'd0, 8'h00);
        rd = 8'hxx;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.m0_done) begin
                rd = bus.rdata;
                break;
            end
        end
        chk("midop_addr12_unchanged", 32'(rd), 32'(old));

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/ram_ctrl.md
RAM_CTRL -- requirements
Module: ram_ctrl

Interface
REQ-001 The block SHALL have parameter INDF_ADDR, default 5'd0, meaning the indirect-access register address.
REQ-002 The block SHALL have parameter FSR_ADDR, default 5'd4, meaning the address of the pointer register used for indirection.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports m0_req / m1_req, input, 1 bit each: access request from requester 0 / 1.
REQ-006 The block SHALL have ports m0_we / m1_we, input, 1 bit each: 1 = write, 0 = read.
REQ-007 The block SHALL have ports m0_addr / m1_addr, input, 5 bits each: target address.
REQ-008 The block SHALL have ports m0_wdata / m1_wdata, input, 8 bits each: write data.
REQ-009 The block SHALL have ports m0_gnt / m1_gnt, output, 1 bit each: one-cycle grant pulse.
REQ-010 The block SHALL have ports m0_done / m1_done, output, 1 bit each: one-cycle completion pulse.
REQ-011 The block SHALL have port rdata, output, 8 bits: read result, valid while a done is high.
REQ-012 The block SHALL have ports ram_we (1 bit), ram_addr (5 bits) and ram_wdata (8 bits), outputs: drive the 32x8 register file, which has a synchronous write and a registered read address.
REQ-013 The block SHALL have port ram_rdata, input, 8 bits: register file read data, valid the cycle after ram_addr is sampled.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, IND, INDW, ACC and RESP.
REQ-016 IDLE: requests SHALL be sampled only in IDLE; on any req, the block grants one requester, pulses its gnt that cycle, and latches that requester's we, addr and wdata.
REQ-017 Arbitration SHALL be round-robin: with both req high, the grant goes to the requester not granted last; with a single req, that requester is granted.
REQ-018 IDLE transitions: a latched addr equal to INDF_ADDR SHALL go to IND; any other addr SHALL go to ACC with effective address = latched addr.
REQ-019 IND: ram_addr SHALL be FSR_ADDR and ram_we SHALL be 0; next state INDW.
REQ-020 INDW: effective address SHALL be latched as ram_rdata[4:0], with ram_rdata[7:5] ignored; next state ACC.
REQ-021 ACC: ram_addr SHALL be the effective address, ram_wdata the latched wdata, and ram_we the latched we; next state RESP.
REQ-022 RESP: the granted requester's done SHALL pulse for 1 cycle, and ram_we SHALL be 0.
REQ-023 RESP: rdata SHALL be ram_rdata for a read and 8'h00 for a write; next state IDLE.
REQ-024 Null access: if the effective address after indirection equals INDF_ADDR, ram_we SHALL stay 0 in ACC and rdata SHALL be 8'h00.
REQ-025 ram_we SHALL be high only in ACC; it SHALL never be high in any other state.
REQ-026 Latency: done SHALL follow gnt by exactly 2 cycles for a direct access and 4 cycles for an indirect access.
REQ-027 After done, the next gnt SHALL occur no earlier than 1 cycle after done, in IDLE.
REQ-028 A requester SHALL hold req and its fields until gnt; the block SHALL ignore req, we, addr and wdata changes after gnt.
REQ-029 A requester dropping req before gnt SHALL cause no side effect.
REQ-030 Outside RESP, rdata SHALL hold its last value.

Reset
REQ-031 On rst low, the block SHALL immediately enter IDLE, regardless of clk.
REQ-032 On rst low, all gnt, done, ram_we and busy outputs SHALL be 0, and ram_addr, ram_wdata and rdata SHALL be 0.
REQ-033 On rst low, the round-robin pointer SHALL favour m0.
REQ-034 Reset asserted mid-access SHALL abort the access: no ram_we pulse and no done; the requester re-requests after reset.
REQ-035 The first grant SHALL be possible in the first clk edge after rst deasserts.

Verification
REQ-036 Direct write then read: m0 writes 8'hA5 to address 8, then reads address 8 -> ram_we high in one cycle only, done 2 cycles after each gnt, rdata = 8'hA5.
REQ-037 Indirect read: write FSR (addr 4) = 8'hE9, write addr 9 = 8'h3C, then read addr 0 -> effective address 9 (upper FSR bits ignored), done 4 cycles after gnt, rdata = 8'h3C.
REQ-038 Null indirect: FSR = 8'h00, write addr 0 with 8'hFF -> no ram_we pulse, done after 4 cycles; a subsequent read of addr 0 returns 8'h00.
REQ-039 Contention: m0 and m1 request continuously after reset -> grants alternate m0, m1, m0, m1; never two gnts in one cycle; busy low for exactly 1 cycle between accesses.
REQ-040 Reset mid-op: assert rst during ACC of an m1 write of 8'h77 to addr 12 -> no done; addr 12 unchanged; after release, both requesting -> m0 granted first.
